// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU responder: data and shift-count widths,
// ALUOp encodings, the control state encoding and a shift-op decode helper.
// Optional feature macro used by the files that import this package:
//   ALU_OVF_EN  -- adds the signed-overflow output for add/sub.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   // ALUOp encodings; 3'b110 and 3'b111 are reserved and produce zero.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b100;
   localparam logic [2:0] OP_SRA = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational add/sub/and/or datapath. Shift and reserved opcodes
// return zero here; shifting is sequenced by the parent.
// Ports:
//   i_a, i_b  operands (DATA_W bits)
//   i_op      ALUOp encoding
//   o_c       result
//   o_ovf     signed overflow of add/sub (only when ALU_OVF_EN is defined)
// -----------------------------------------------------------------------------
module alu_comb
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [2:0]        i_op,
   output logic [DATA_W-1:0] o_c
`ifdef ALU_OVF_EN
   ,
   output logic              o_ovf
`endif
);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves o_c
      // unassigned -- that is what keeps a latch from being inferred.
      o_c = '0;
      case (i_op)
         OP_ADD:  o_c = i_a + i_b;
         OP_SUB:  o_c = i_a - i_b;
         OP_AND:  o_c = i_a & i_b;
         OP_OR:   o_c = i_a | i_b;
         default: o_c = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   // Overflow when the result sign disagrees with what the operand signs allow.
   always_comb begin
      o_ovf = 1'b0;
      case (i_op)
         OP_ADD:  o_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (o_c[DATA_W-1] != i_a[DATA_W-1]);
         OP_SUB:  o_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (o_c[DATA_W-1] != i_a[DATA_W-1]);
         default: o_ovf = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/alu_responder.sv
// -----------------------------------------------------------------------------
// alu_responder
// Valid/ready ALU. One request in flight at a time: IDLE accepts, SHIFT walks
// a shift one bit per cycle, DONE holds the result until the consumer takes it.
// Optional feature macro: ALU_OVF_EN -- adds the ovf output for add/sub.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready request handshake (ready only in IDLE)
//   A, B, ALUOp           operands and opcode, captured on acceptance
//   rsp_valid / rsp_ready response handshake (valid only in DONE)
//   C                     result, held stable while rsp_valid=1
//   ovf                   signed overflow of add/sub (ALU_OVF_EN only)
// -----------------------------------------------------------------------------
module alu_responder
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [2:0]        ALUOp,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] C
`ifdef ALU_OVF_EN
   ,
   output logic              ovf
`endif
);

   state_t               r_state;
   logic [2:0]           r_op;
   logic [SHAMT_W-1:0]   r_cnt;
   // Working register during SHIFT, result register in DONE.
   logic [DATA_W-1:0]    r_c;

   logic [DATA_W-1:0]    w_alu_c;
   logic                 w_accept;
   logic                 w_fill;
`ifdef ALU_OVF_EN
   logic                 w_alu_ovf;
   logic                 r_ovf;
`endif

   alu_comb u_alu_comb (
      .i_a   (A),
      .i_b   (B),
      .i_op  (ALUOp),
      .o_c   (w_alu_c)
`ifdef ALU_OVF_EN
      ,
      .o_ovf (w_alu_ovf)
`endif
   );

   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   // The working register's MSB is still A[31], so sra refills with the sign.
   assign w_fill    = (r_op == OP_SRA) ? r_c[DATA_W-1] : 1'b0;

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_DONE);
   assign C         = r_c;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every control and data register is cleared asynchronously so
      // rsp_valid and C drop the instant rst_n falls, discarding any operation.
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= OP_ADD;
         r_cnt   <= '0;
         r_c     <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge value of every other one.
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op <= ALUOp;
                  if (is_shift_op(ALUOp)) begin
                     r_c   <= A;
                     r_cnt <= B[SHAMT_W-1:0];
                     // A zero shift amount needs no SHIFT cycles at all.
                     r_state <= (B[SHAMT_W-1:0] == '0) ? ST_DONE : ST_SHIFT;
                  end else begin
                     r_c     <= w_alu_c;
                     r_cnt   <= '0;
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_SHIFT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_c   <= {w_fill, r_c[DATA_W-1:1]};
                  r_cnt <= r_cnt - 1'b1;
                  // Leave on the edge that performs the final shift.
                  if (r_cnt == SHAMT_W'(1)) begin
                     r_state <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               if (rsp_ready) begin
                  r_state <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_OVF_EN
   // alu_comb reports zero overflow for shifts and reserved ops, so the flag
   // can simply be captured on every acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= w_alu_ovf;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_responder.sv
// -----------------------------------------------------------------------------
// tb_alu_responder
// Self-checking bench for alu_responder. Expected results come from a
// behavioural model (plain arithmetic on the operands, latency 1 or 1+shamt).
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with +define+ALU_OVF_EN to also exercise the ovf output.
// -----------------------------------------------------------------------------
module tb_alu_responder;

   localparam longint MAX_S32 = 64'sd2147483647;
   localparam longint MIN_S32 = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUOp;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] C;
`ifdef ALU_OVF_EN
   logic        ovf;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .A         (A),
      .B         (B),
      .ALUOp     (ALUOp),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
`ifdef ALU_OVF_EN
      .ovf       (ovf),
`endif
      .C         (C)
   );

   // Reference model: result, overflow flag and cycles from acceptance to rsp_valid.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c, output logic v, output int lat);
      longint sa, sb, s;
      int     sh;
      sa  = $signed(a);
      sb  = $signed(b);
      sh  = int'(b[4:0]);
      c   = 32'h0;
      v   = 1'b0;
      lat = 1;
      case (op)
         3'b000: begin c = a + b; s = sa + sb; v = (s > MAX_S32) || (s < MIN_S32); end
         3'b001: begin c = a - b; s = sa - sb; v = (s > MAX_S32) || (s < MIN_S32); end
         3'b010: c = a & b;
         3'b011: c = a | b;
         3'b100: begin c = a >> sh; lat = 1 + sh; end
         3'b101: begin c = $unsigned($signed(a) >>> sh); lat = 1 + sh; end
         default: c = 32'h0;
      endcase
   endtask

   // Present one request; returns at the first falling edge after acceptance
   // with the inputs scrambled to prove the in-flight result is insensitive.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1)
         $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
      else
         n_pass++;
      req_valid = 1'b1;
      ALUOp     = op;
      A         = a;
      B         = b;
      @(negedge clk);
      req_valid = 1'b0;
      A         = $urandom;
      B         = $urandom;
      ALUOp     = 3'($urandom);
   endtask

   // Full transaction: issue, check exact latency and result, hold for
   // hold_n cycles with rsp_ready low, then complete the handshake.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, input string tag);
      logic [31:0] exp_c;
      logic        exp_v;
      int          lat;
      bit          early;
      model(op, a, b, exp_c, exp_v, lat);
      issue(op, a, b, tag);
      early = 1'b0;
      for (int k = 1; k < lat; k++) begin
         if (rsp_valid !== 1'b0) early = 1'b1;
         @(negedge clk);
      end
      n_total++;
      if (early) $display("FAIL %s early_rsp: rsp_valid seen before cycle %0d", tag, lat);
      else n_pass++;
      n_total++;
      if (rsp_valid !== 1'b1) $display("FAIL %s rsp_valid_at_latency: got %b want 1 (lat %0d)", tag, rsp_valid, lat);
      else n_pass++;
      n_total++;
      if (C !== exp_c) $display("FAIL %s result: got %h want %h", tag, C, exp_c);
      else n_pass++;
`ifdef ALU_OVF_EN
      n_total++;
      if (ovf !== exp_v) $display("FAIL %s ovf: got %b want %b", tag, ovf, exp_v);
      else n_pass++;
`endif
      for (int h = 0; h < hold_n; h++) begin
         @(negedge clk);
         n_total++;
         if (rsp_valid !== 1'b1 || C !== exp_c || req_ready !== 1'b0)
            $display("FAIL %s hold: valid %b C %h ready %b want 1 %h 0", tag, rsp_valid, C, req_ready, exp_c);
         else n_pass++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL %s handshake: valid %b ready %b want 0 1", tag, rsp_valid, req_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      A         = 32'h0;
      B         = 32'h0;
      ALUOp     = 3'b000;
      repeat (3) @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0 || C !== 32'h0)
         $display("FAIL reset_outputs: valid %b C %h want 0 00000000", rsp_valid, C);
      else n_pass++;
`ifdef ALU_OVF_EN
      n_total++;
      if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
      else n_pass++;
`endif
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL reset_release: ready %b valid %b want 1 0", req_ready, rsp_valid);
      else n_pass++;
   endtask

   task automatic test_directed();
      run_op(3'b101, 32'hF0F0_F0F0, 32'd8,         0, "sra8");
      run_op(3'b100, 32'hF0F0_F0F0, 32'd8,         0, "srl8");
      run_op(3'b100, 32'hF0F0_F0F0, 32'd0,         0, "srl0");
      run_op(3'b101, 32'h8000_0001, 32'd31,        0, "sra31");
      run_op(3'b100, 32'h8765_4321, 32'hFFFF_FFE3, 0, "srl_hi_b_ignored");
      run_op(3'b000, 32'h7FFF_FFFF, 32'd1,         0, "add_ovf");
      run_op(3'b001, 32'h0000_0000, 32'd1,         0, "sub_wrap");
      run_op(3'b001, 32'h8000_0000, 32'd1,         0, "sub_ovf");
      run_op(3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, "and");
      run_op(3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, "or");
      run_op(3'b110, 32'hFFFF_FFFF, 32'h1234_5678, 0, "rsvd110");
      run_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "rsvd111");
   endtask

   // Response held off for 5 cycles while a second request is presented.
   task automatic test_hold_and_ignore();
      logic [31:0] exp_c;
      logic        exp_v;
      int          lat;
      model(3'b000, 32'h1111_1111, 32'h2222_2222, exp_c, exp_v, lat);
      issue(3'b000, 32'h1111_1111, 32'h2222_2222, "hold");
      n_total++;
      if (rsp_valid !== 1'b1 || C !== exp_c)
         $display("FAIL hold first_rsp: valid %b C %h want 1 %h", rsp_valid, C, exp_c);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         ALUOp     = 3'b011;
         A         = $urandom;
         B         = $urandom;
         @(negedge clk);
         n_total++;
         if (rsp_valid !== 1'b1 || C !== exp_c || req_ready !== 1'b0)
            $display("FAIL hold stall%0d: valid %b C %h ready %b want 1 %h 0", i, rsp_valid, C, req_ready, exp_c);
         else n_pass++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL hold release: ready %b valid %b want 1 0", req_ready, rsp_valid);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0)
         $display("FAIL hold ignored_req: rsp_valid got %b want 0", rsp_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid_shift();
      bit seen;
      issue(3'b101, 32'hF0F0_F0F0, 32'd31, "rst_shift");
      repeat (10) @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL rst_shift still_busy: rsp_valid got %b want 0", rsp_valid);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (rsp_valid !== 1'b0 || C !== 32'h0)
         $display("FAIL rst_shift immediate_clear: valid %b C %h want 0 00000000", rsp_valid, C);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      n_total++;
      if (seen) $display("FAIL rst_shift discarded: response appeared after reset");
      else n_pass++;
      run_op(3'b000, 32'h0000_0005, 32'h0000_0007, 0, "add_after_rst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_hold_and_ignore();
      test_reset_mid_shift();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
